// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: datapath widths, address base and FSM states.
package mem_stage_pkg;

  localparam int REGISTER_LEN    = 32;
  localparam int REG_ADDRESS_LEN = 4;
  localparam int MEM_ADDR_W      = 6;
  localparam int MEM_ADDR_BASE   = 1024;

  typedef enum logic [1:0] {
    MEM_STATE_IDLE = 2'd0,
    MEM_STATE_WAIT = 2'd1,
    MEM_STATE_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/mem_stage_reg.sv
// MEM/WB pipeline register; a bubble clears every field so WB sees a no-op.
module mem_stage_reg
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = REGISTER_LEN,
  parameter int REG_ADDR_W = REG_ADDRESS_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bubble,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [DATA_W-1:0]     mem_data_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      alu_res_out  <= '0;
      mem_data_out <= '0;
      dest_out     <= '0;
    end else begin
      wb_en_out    <= wb_en_in;
      mem_r_en_out <= mem_r_en_in;
      alu_res_out  <= alu_res_in;
      mem_data_out <= mem_data_in;
      dest_out     <= dest_in;
    end
  end

endmodule

// File: rtl/mem_stage_module.sv
// MEM stage: runs loads/stores over a req/ack word-memory port, freezing upstream
// stages while an access is outstanding, and feeds the MEM/WB register.
module mem_stage_module
  import mem_stage_pkg::*;
#(
  parameter int DATA_W     = REGISTER_LEN,
  parameter int REG_ADDR_W = REG_ADDRESS_LEN,
  parameter int MEM_AW     = MEM_ADDR_W,
  parameter int ADDR_BASE  = MEM_ADDR_BASE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic [DATA_W-1:0]     alu_res_in,
  input  logic [DATA_W-1:0]     val_Rm_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  output logic                  freeze_out,
  output logic                  wb_en_hazard_out,
  output logic [REG_ADDR_W-1:0] dest_hazard_out,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [MEM_AW-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_ack,
  output logic                  wb_en_out,
  output logic                  mem_r_en_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [DATA_W-1:0]     mem_data_out,
  output logic [REG_ADDR_W-1:0] dest_out
);

  mem_state_e              state_reg, state_next;
  logic                    mem_req_reg, mem_we_reg;
  logic [MEM_AW-1:0]       mem_addr_reg;
  logic [DATA_W-1:0]       mem_wdata_reg, hold_reg;
  logic                    access;
  logic [MEM_AW-1:0]       word_addr;
  logic                    bubble;
  logic [DATA_W-1:0]       wb_mem_data;

  assign access           = mem_r_en_in | mem_w_en_in;
  assign wb_en_hazard_out = wb_en_in;
  assign dest_hazard_out  = dest_in;

  // Offset from the data-segment base wraps modulo 2^DATA_W; byte bits dropped.
  assign word_addr = MEM_AW'((alu_res_in - DATA_W'(ADDR_BASE)) >> 2);

  assign mem_req   = mem_req_reg;
  assign mem_we    = mem_we_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  always_comb begin
    state_next  = state_reg;
    freeze_out  = 1'b0;
    bubble      = 1'b0;
    wb_mem_data = '0;
    case (state_reg)
      MEM_STATE_IDLE: begin
        if (access) begin
          freeze_out = 1'b1;
          bubble     = 1'b1;
          state_next = MEM_STATE_WAIT;
        end
      end
      MEM_STATE_WAIT: begin
        freeze_out = 1'b1;
        bubble     = 1'b1;
        if (mem_ack) state_next = MEM_STATE_DONE;
      end
      MEM_STATE_DONE: begin
        wb_mem_data = mem_we_reg ? '0 : hold_reg;
        state_next  = MEM_STATE_IDLE;
      end
      default: state_next = MEM_STATE_IDLE;
    endcase
    if (rst) freeze_out = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= MEM_STATE_IDLE;
      mem_req_reg   <= 1'b0;
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      hold_reg      <= '0;
    end else begin
      state_reg <= state_next;
      // A load wins over a simultaneous store, so we is only the store-alone case.
      if (state_reg == MEM_STATE_IDLE && access) begin
        mem_req_reg   <= 1'b1;
        mem_we_reg    <= ~mem_r_en_in;
        mem_addr_reg  <= word_addr;
        mem_wdata_reg <= val_Rm_in;
      end
      if (state_reg == MEM_STATE_WAIT && mem_ack) begin
        mem_req_reg <= 1'b0;
        hold_reg    <= mem_rdata;
      end
    end
  end

  mem_stage_reg #(
    .DATA_W    (DATA_W),
    .REG_ADDR_W(REG_ADDR_W)
  ) u_mem_wb (
    .clk         (clk),
    .rst         (rst),
    .bubble      (bubble),
    .wb_en_in    (wb_en_in),
    .mem_r_en_in (mem_r_en_in),
    .alu_res_in  (alu_res_in),
    .mem_data_in (wb_mem_data),
    .dest_in     (dest_in),
    .wb_en_out   (wb_en_out),
    .mem_r_en_out(mem_r_en_out),
    .alu_res_out (alu_res_out),
    .mem_data_out(mem_data_out),
    .dest_out    (dest_out)
  );

endmodule

// File: tb/tb_mem_stage_module.sv
// Bench for mem_stage_module: directed and random instructions against a word-array
// memory model that answers each request after a chosen number of ack-free cycles.
module tb_mem_stage_module;

  localparam logic [31:0] BASE = 32'd1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_en_in, mem_r_en_in, mem_w_en_in;
  logic [31:0] alu_res_in, val_Rm_in;
  logic [3:0]  dest_in;
  logic        freeze_out, wb_en_hazard_out;
  logic [3:0]  dest_hazard_out;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        wb_en_out, mem_r_en_out;
  logic [31:0] alu_res_out, mem_data_out;
  logic [3:0]  dest_out;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_model [64];

  always #5 clk = ~clk;

  mem_stage_module dut (
    .clk             (clk),
    .rst             (rst),
    .wb_en_in        (wb_en_in),
    .mem_r_en_in     (mem_r_en_in),
    .mem_w_en_in     (mem_w_en_in),
    .alu_res_in      (alu_res_in),
    .val_Rm_in       (val_Rm_in),
    .dest_in         (dest_in),
    .freeze_out      (freeze_out),
    .wb_en_hazard_out(wb_en_hazard_out),
    .dest_hazard_out (dest_hazard_out),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_ack         (mem_ack),
    .wb_en_out       (wb_en_out),
    .mem_r_en_out    (mem_r_en_out),
    .alu_res_out     (alu_res_out),
    .mem_data_out    (mem_data_out),
    .dest_out        (dest_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One instruction from EX/MEM, held while frozen; lat = ack-free WAIT cycles.
  task automatic run_instr(input logic wb, input logic r, input logic w,
                           input logic [31:0] alu, input logic [31:0] rm,
                           input logic [3:0] dst, input int lat, input logic spur);
    logic       access;
    logic [5:0] waddr;
    logic [31:0] exp_data;
    int         frz;
    access   = r | w;
    waddr    = 6'((alu - BASE) >> 2);
    exp_data = 32'd0;
    frz      = 0;
    wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
    alu_res_in = alu; val_Rm_in = rm; dest_in = dst;
    mem_ack = spur; mem_rdata = $urandom;
    #1;
    chk("haz_wb", wb_en_hazard_out, wb);
    chk("haz_dest", dest_hazard_out, dst);
    if (freeze_out) frz++;
    step();
    if (access) begin
      chk("req_rise", mem_req, 1);
      chk("we", mem_we, !r);
      chk("addr", mem_addr, waddr);
      if (!r) chk("wdata", mem_wdata, rm);
      chk("bubble_issue", wb_en_out, 0);
      for (int k = 0; k <= lat; k++) begin
        mem_ack   = (k == lat);
        mem_rdata = (k == lat && r) ? mem_model[waddr] : $urandom;
        #1;
        if (freeze_out) frz++;
        chk("haz_dest_frozen", dest_hazard_out, dst);
        chk("req_held", mem_req, 1);
        chk("addr_held", mem_addr, waddr);
        chk("we_held", mem_we, !r);
        step();
        chk("bubble_wait", wb_en_out, 0);
      end
      if (r) exp_data = mem_model[waddr];
      else   mem_model[waddr] = rm;
      mem_ack = 1'b0; mem_rdata = $urandom;
      #1;
      if (freeze_out) frz++;
      chk("req_drop", mem_req, 0);
      step();
    end
    chk("wb_en_out", wb_en_out, wb);
    chk("mem_r_en_out", mem_r_en_out, r);
    chk("alu_res_out", alu_res_out, alu);
    chk("mem_data_out", mem_data_out, exp_data);
    chk("dest_out", dest_out, dst);
    chk("freeze_cycles", frz, access ? lat + 2 : 0);
    $display("instr wb=%0d r=%0d w=%0d alu=%h rm=%h dest=%0d lat=%0d data=%h", wb, r, w, alu, rm, dst, lat, exp_data);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
    mem_model[2] = 32'hDEADBEEF;

    // Reset with a pending access on the inputs: freeze must stay low.
    rst = 1'b1; wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b1;
    alu_res_in = 32'd1040; val_Rm_in = 32'h1; dest_in = 4'd7;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    step();
    chk("rst_freeze", freeze_out, 0);
    step();
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_wb_en_out", wb_en_out, 0);
    chk("rst_alu_res_out", alu_res_out, 0);
    chk("rst_dest_out", dest_out, 0);
    rst = 1'b0; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0;
    $display("reset checked");

    run_instr(1'b1, 1'b0, 1'b0, 32'h55, 32'h0, 4'd3, 0, 1'b0);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1032, 32'h0, 4'd4, 1, 1'b0);
    run_instr(1'b0, 1'b0, 1'b1, 32'd1028, 32'h12345678, 4'd0, 0, 1'b0);
    run_instr(1'b1, 1'b1, 1'b1, 32'd1024, 32'hCAFEF00D, 4'd6, 0, 1'b0);
    run_instr(1'b1, 1'b1, 1'b0, 32'd1028, 32'h0, 4'd8, 2, 1'b0);
    run_instr(1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 4'd9, 0, 1'b0);
    run_instr(1'b1, 1'b0, 1'b0, 32'h1234, 32'h0, 4'd1, 0, 1'b1);

    // Reset while waiting for the ack; the late ack afterwards must be ignored.
    wb_en_in = 1'b1; mem_r_en_in = 1'b1; mem_w_en_in = 1'b0;
    alu_res_in = 32'd1100; dest_in = 4'd2; mem_ack = 1'b0;
    step();
    chk("rst_wait_req", mem_req, 1);
    rst = 1'b1;
    #1;
    chk("rst_wait_freeze", freeze_out, 0);
    step();
    rst = 1'b0; wb_en_in = 1'b0; mem_r_en_in = 1'b0; alu_res_in = 32'd0; dest_in = 4'd0;
    #1;
    chk("rst_wait_req_drop", mem_req, 0);
    chk("rst_wait_freeze_after", freeze_out, 0);
    chk("rst_wait_wb_en_out", wb_en_out, 0);
    chk("rst_wait_mem_r_en_out", mem_r_en_out, 0);
    chk("rst_wait_alu_res_out", alu_res_out, 0);
    chk("rst_wait_mem_data_out", mem_data_out, 0);
    chk("rst_wait_dest_out", dest_out, 0);
    $display("reset during wait checked");
    run_instr(1'b1, 1'b0, 1'b0, 32'h77, 32'h0, 4'd5, 0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          op;
      op = $urandom_range(0, 3);
      a  = ($urandom_range(0, 7) == 0) ? $urandom
                                       : BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      run_instr(1'($urandom_range(0, 1)), op == 1 || op == 3, op == 2 || op == 3,
                a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                1'($urandom_range(0, 1)) && op == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
